rr_arbiter4_ctrl: RTL and testbench

- Sequential 4-requester round-robin arbiter that shares a single downstream resource (bus, encoder-fed datapath) between four requesters.
- Produces a one-hot grant plus its 2-bit encoded index, which is the 4:2 encoding of the grant.
- Enforces fairness by rotating priority after each grant and by optionally forcing release after a bounded hold time.
- Sits between the requester ports and the shared resource's select/enable logic.

---
 rtl/rr_arbiter4_ctrl_if.sv | 25 ++
 rtl/rr_arbiter4_ctrl.sv | 111 +++++++++++
 tb/tb_rr_arbiter4_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_ctrl_if.sv
// Requester/arbiter handshake bundle for the 4-way round-robin arbiter.
// The requester side drives en/req; the arbiter drives the registered grant.
interface rr_arbiter4_ctrl_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid
    );
endinterface

// File: rtl/rr_arbiter4_ctrl.sv
// Four-requester round-robin arbiter with a dead cycle between owners and
// a bounded hold time whenever another requester is waiting.
module rr_arbiter4_ctrl #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    rr_arbiter4_ctrl_if.slave arb
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       id_q, id_d;
    logic [1:0]       last_q, last_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       found;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       others_pending;
    logic       release_now;

    // Priority search starting just after the last owner, wrapping 3 -> 0.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && arb.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // The counter saturates at HOLD_MAX, so a late challenger must still
    // trigger the forced release once the limit has been reached.
    assign others_pending = |(arb.req & ~gnt_q);
    assign release_now    = !arb.req[id_q] || !arb.en ||
                            ((cnt_q >= HOLD_LAST) && others_pending);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        last_d  = last_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb.en && found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << winner;
                    id_d    = winner;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                    last_d  = id_q;
                    cnt_d   = '0;
                end else if (cnt_q != HOLD_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            id_q    <= 2'd0;
            last_q  <= 2'd3;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.gnt_id    = id_q;
    assign arb.gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter4_ctrl.sv
// Directed bench for rr_arbiter4_ctrl: vector table for release/enable
// behaviour plus hand sequences for rotation, sole owner and async reset.
module tb_rr_arbiter4_ctrl;

    localparam int unsigned HOLD_MAX = 8;

    logic clk;
    logic rst;

    rr_arbiter4_ctrl_if arb_if ();

    rr_arbiter4_ctrl #(
        .HOLD_MAX(HOLD_MAX),
        .CNT_W   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .arb(arb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [3:0] eg,
                         input logic [1:0] eid, input logic ev);
        n_checks++;
        if (arb_if.gnt !== eg || arb_if.gnt_id !== eid || arb_if.gnt_valid !== ev) begin
            n_errors++;
            $display("FAIL %s: got gnt=%b id=%0d valid=%b, expected gnt=%b id=%0d valid=%b",
                     name, arb_if.gnt, arb_if.gnt_id, arb_if.gnt_valid, eg, eid, ev);
        end
    endtask

    // Drive inputs, let one rising edge pass, return at the falling edge.
    task automatic cyc(input logic e, input logic [3:0] r);
        arb_if.en  = e;
        arb_if.req = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] oid;
        logic       released;

        // Release/enable scenarios; state entering: IDLE, last owner 0.
        vecs[0]  = '{1'b1, 4'b1101, 4'b0100, 2'd2, 1'b1};
        vecs[1]  = '{1'b1, 4'b1101, 4'b0100, 2'd2, 1'b1};
        vecs[2]  = '{1'b1, 4'b1101, 4'b0100, 2'd2, 1'b1};
        vecs[3]  = '{1'b1, 4'b1001, 4'b0000, 2'd2, 1'b0};
        vecs[4]  = '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1};
        vecs[5]  = '{1'b0, 4'b1111, 4'b0000, 2'd3, 1'b0};
        vecs[6]  = '{1'b0, 4'b1111, 4'b0000, 2'd3, 1'b0};
        vecs[7]  = '{1'b0, 4'b1111, 4'b0000, 2'd3, 1'b0};
        vecs[8]  = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1};
        vecs[9]  = '{1'b1, 4'b1110, 4'b0000, 2'd0, 1'b0};
        vecs[10] = '{1'b1, 4'b1110, 4'b0010, 2'd1, 1'b1};
        vecs[11] = '{1'b0, 4'b1111, 4'b0000, 2'd1, 1'b0};
        vecs[12] = '{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1};
        vecs[13] = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};
        vecs[14] = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};

        rst        = 1'b0;
        arb_if.en  = 1'b1;
        arb_if.req = 4'b1111;
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        cyc(1'b1, 4'b1111);
        check("first_grant", 4'b0001, 2'd0, 1'b1);

        // Full contention: each owner holds 8 cycles, then one dead cycle.
        for (int o = 0; o < 5; o++) begin
            oid = 2'(o % 4);
            for (int c = (o == 0) ? 1 : 0; c < 8; c++) begin
                cyc(1'b1, 4'b1111);
                check("rr_hold", 4'b0001 << oid, oid, 1'b1);
            end
            cyc(1'b1, 4'b1111);
            check("rr_dead", 4'b0000, oid, 1'b0);
        end

        for (int i = 0; i < NVEC; i++) begin
            cyc(vecs[i].en, vecs[i].req);
            check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].valid);
        end

        // Sole requester keeps the grant well past HOLD_MAX.
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 4'b0100);
            check("sole_hold", 4'b0100, 2'd2, 1'b1);
        end
        released = 1'b0;
        for (int i = 0; i < int'(HOLD_MAX) && !released; i++) begin
            cyc(1'b1, 4'b0101);
            if (arb_if.gnt == 4'b0000) released = 1'b1;
            else check("sole_challenged", 4'b0100, 2'd2, 1'b1);
        end
        n_checks++;
        if (!released) begin
            n_errors++;
            $display("FAIL sole_release: got gnt=%b, expected release within %0d cycles",
                     arb_if.gnt, HOLD_MAX);
        end
        check("sole_dead", 4'b0000, 2'd2, 1'b0);
        cyc(1'b1, 4'b0101);
        check("sole_next", 4'b0001, 2'd0, 1'b1);

        // Move ownership to requester 3, then reset between edges.
        cyc(1'b1, 4'b1000);
        check("pre_rst_dead", 4'b0000, 2'd0, 1'b0);
        cyc(1'b1, 4'b1000);
        check("pre_rst_grant", 4'b1000, 2'd3, 1'b1);
        #2 rst = 1'b1;
        #1 check("async_rst", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        check("rst_held", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        cyc(1'b1, 4'b1111);
        check("post_rst_grant", 4'b0001, 2'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
